// File: rtl/master_epoch_sched.sv
// Epoch scheduler: streams operand and lagged v_gidx SRAM read addresses into
// master_top, then waits for its finish flag and reports done/error status.
module master_epoch_sched #(
  parameter int MAX_EPOCH = 256,
  parameter int EPOCH_BW  = 8,
  parameter int VG_LAG    = 3,
  parameter int TIMEOUT   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stall,
  input  logic                mst_finish,
  output logic                op_ren,
  output logic [EPOCH_BW-1:0] op_raddr,
  output logic                vg_ren,
  output logic [EPOCH_BW-1:0] vg_raddr,
  output logic                mst_enable,
  output logic                busy,
  output logic                done,
  output logic                sync_err,
  output logic                timeout_err
);
  localparam int IW = (VG_LAG > 0) ? $clog2(VG_LAG + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [EPOCH_BW-1:0] LAST = EPOCH_BW'(MAX_EPOCH - 1);
  localparam logic [IW-1:0]       LAG  = IW'(VG_LAG);
  localparam logic [TW-1:0]       TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WAIT_FIN, DONE} state_t;

  state_t              state_q;
  logic [EPOCH_BW-1:0] op_cnt_q, vg_cnt_q, op_raddr_q, vg_raddr_q;
  logic [IW-1:0]       issued_q;
  logic [TW-1:0]       tmo_q;
  logic                op_ren_q, vg_ren_q, mst_en_q, busy_q, done_q;
  logic                sync_err_q, timeout_err_q;

  // Outputs are registered and reflect the state entered at each edge; an
  // address register always shows the pending address, ren marks a real issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      op_cnt_q      <= '0;
      vg_cnt_q      <= '0;
      issued_q      <= '0;
      tmo_q         <= '0;
      op_raddr_q    <= '0;
      vg_raddr_q    <= '0;
      op_ren_q      <= 1'b0;
      vg_ren_q      <= 1'b0;
      mst_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      sync_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      op_ren_q <= 1'b0;
      vg_ren_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q       <= RUN;
          op_cnt_q      <= '0;
          vg_cnt_q      <= '0;
          issued_q      <= '0;
          tmo_q         <= '0;
          sync_err_q    <= 1'b0;
          timeout_err_q <= 1'b0;
          busy_q        <= 1'b1;
          mst_en_q      <= 1'b1;
        end
        RUN: begin
          if (mst_finish) sync_err_q <= 1'b1;
          op_raddr_q <= op_cnt_q;
          vg_raddr_q <= vg_cnt_q;
          if (!stall) begin
            op_ren_q <= 1'b1;
            vg_ren_q <= 1'b1;
            // vg_cnt stays clamped at 0 until VG_LAG operands have gone out
            if (issued_q == LAG) vg_cnt_q <= vg_cnt_q + 1'b1;
            else                 issued_q <= issued_q + 1'b1;
            if (op_cnt_q == LAST) state_q <= (VG_LAG == 0) ? WAIT_FIN : DRAIN;
            else                  op_cnt_q <= op_cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (mst_finish) sync_err_q <= 1'b1;
          op_raddr_q <= LAST;
          vg_raddr_q <= vg_cnt_q;
          if (!stall) begin
            op_ren_q <= 1'b1;
            vg_ren_q <= 1'b1;
            if (vg_cnt_q == LAST) state_q  <= WAIT_FIN;
            else                  vg_cnt_q <= vg_cnt_q + 1'b1;
          end
        end
        WAIT_FIN: begin
          if (mst_finish || tmo_q == TMAX) begin
            if (!mst_finish) timeout_err_q <= 1'b1;
            state_q  <= DONE;
            busy_q   <= 1'b0;
            mst_en_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_ren      = op_ren_q;
  assign op_raddr    = op_raddr_q;
  assign vg_ren      = vg_ren_q;
  assign vg_raddr    = vg_raddr_q;
  assign mst_enable  = mst_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sync_err    = sync_err_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_master_epoch_sched.sv
// Directed bench for master_epoch_sched: vector table for the pass start-up,
// hand sequences for stall, drain, finish, sync/timeout errors and reset abort.
module tb_master_epoch_sched;
  logic       clk = 1'b0;
  logic       rst, start, stall, mst_finish;
  logic       op_ren, vg_ren, mst_enable, busy, done, sync_err, timeout_err;
  logic [7:0] op_raddr, vg_raddr;
  int         n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  master_epoch_sched dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .mst_finish(mst_finish),
    .op_ren(op_ren), .op_raddr(op_raddr), .vg_ren(vg_ren), .vg_raddr(vg_raddr),
    .mst_enable(mst_enable), .busy(busy), .done(done),
    .sync_err(sync_err), .timeout_err(timeout_err)
  );

  // {op_ren, op_raddr, vg_ren, vg_raddr, busy, mst_enable, done, sync_err, timeout_err}
  function automatic logic [22:0] pk(input logic r, input logic [7:0] o, input logic vr,
                                     input logic [7:0] v, input logic b, input logic e,
                                     input logic d, input logic s, input logic t);
    return {r, o, vr, v, b, e, d, s, t};
  endfunction

  function automatic logic [22:0] obs();
    return {op_ren, op_raddr, vg_ren, vg_raddr, busy, mst_enable, done, sync_err, timeout_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_op(input int tgt);
    int n = 0;
    while (!(op_ren && op_raddr == 8'(tgt)) && n < 600) begin tick(); n++; end
    chk("reach_op", 32'(n < 600), 32'd1);
  endtask

  typedef struct {
    logic        st;
    logic        sl;
    logic [22:0] exp;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int n;
    tbl[0]  = '{1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b1, 1'b0, pk(0, 0, 0, 0, 1, 1, 0, 0, 0)};
    tbl[2]  = '{1'b0, 1'b0, pk(1, 0, 1, 0, 1, 1, 0, 0, 0)};
    tbl[3]  = '{1'b0, 1'b0, pk(1, 1, 1, 0, 1, 1, 0, 0, 0)};
    tbl[4]  = '{1'b0, 1'b0, pk(1, 2, 1, 0, 1, 1, 0, 0, 0)};
    tbl[5]  = '{1'b0, 1'b0, pk(1, 3, 1, 0, 1, 1, 0, 0, 0)};
    tbl[6]  = '{1'b0, 1'b0, pk(1, 4, 1, 1, 1, 1, 0, 0, 0)};
    tbl[7]  = '{1'b1, 1'b0, pk(1, 5, 1, 2, 1, 1, 0, 0, 0)};  // start ignored in RUN
    tbl[8]  = '{1'b0, 1'b1, pk(0, 6, 0, 3, 1, 1, 0, 0, 0)};
    tbl[9]  = '{1'b0, 1'b1, pk(0, 6, 0, 3, 1, 1, 0, 0, 0)};
    tbl[10] = '{1'b0, 1'b0, pk(1, 6, 1, 3, 1, 1, 0, 0, 0)};
    tbl[11] = '{1'b0, 1'b0, pk(1, 7, 1, 4, 1, 1, 0, 0, 0)};

    rst = 1'b1; start = 1'b0; stall = 1'b0; mst_finish = 1'b0;
    tick(); tick();
    chk("reset_state", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    rst = 1'b0;

    // Pass 1: clean pass with stalls in RUN and DRAIN
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st; stall = tbl[i].sl;
      tick();
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
    end
    start = 1'b0; stall = 1'b0;
    for (int op = 8; op < 100; op++) begin
      tick();
      chk("run_lo", 32'(obs()), 32'(pk(1, 8'(op), 1, 8'(op - 3), 1, 1, 0, 0, 0)));
    end
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_run", 32'(obs()), 32'(pk(0, 100, 0, 97, 1, 1, 0, 0, 0)));
    end
    stall = 1'b0;
    tick(); chk("resume_100", 32'(obs()), 32'(pk(1, 100, 1, 97, 1, 1, 0, 0, 0)));
    tick(); chk("resume_101", 32'(obs()), 32'(pk(1, 101, 1, 98, 1, 1, 0, 0, 0)));
    for (int op = 102; op < 256; op++) begin
      tick();
      chk("run_hi", 32'(obs()), 32'(pk(1, 8'(op), 1, 8'(op - 3), 1, 1, 0, 0, 0)));
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_drain", 32'(obs()), 32'(pk(0, 255, 0, 253, 1, 1, 0, 0, 0)));
    end
    stall = 1'b0;
    for (int v = 253; v < 256; v++) begin
      tick();
      chk("drain", 32'(obs()), 32'(pk(1, 255, 1, 8'(v), 1, 1, 0, 0, 0)));
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("wait_fin", 32'(obs()), 32'(pk(0, 255, 0, 255, 1, 1, 0, 0, 0)));
    end
    mst_finish = 1'b1;
    tick(); chk("done_pulse", 32'(obs()), 32'(pk(0, 255, 0, 255, 0, 0, 1, 0, 0)));
    mst_finish = 1'b0; start = 1'b1;  // start in DONE is ignored
    tick(); chk("idle_after", 32'(obs()), 32'(pk(0, 255, 0, 255, 0, 0, 0, 0, 0)));
    start = 1'b0;
    tick(); chk("idle_stays", 32'(busy), 32'd0);

    // Pass 2: early finish flags sync_err, pass still completes
    start = 1'b1; tick(); start = 1'b0;
    run_to_op(50);
    mst_finish = 1'b1; tick(); mst_finish = 1'b0;
    chk("serr_set", 32'(sync_err), 32'd1);
    chk("serr_continue", 32'(op_raddr), 32'd51);
    n = 0;
    while (!(op_ren && vg_raddr == 8'd255) && n < 600) begin tick(); n++; end
    chk("drain_end", 32'(n < 600), 32'd1);
    chk("serr_sticky", 32'(sync_err), 32'd1);
    tick(); mst_finish = 1'b1; tick(); mst_finish = 1'b0;
    chk("done_serr", 32'(obs()), 32'(pk(0, 255, 0, 255, 0, 0, 1, 1, 0)));
    tick(); chk("idle_serr", 32'({busy, done, sync_err}), 32'b001);

    // Pass 3: start clears sync_err; no finish -> timeout after 1024 WAIT cycles
    start = 1'b1; tick(); start = 1'b0;
    chk("serr_clr", 32'({busy, sync_err}), 32'b10);
    n = 0;
    while (!done && n < 3000) begin tick(); n++; end
    chk("tmo_cycles", 32'(n), 32'd1283);
    chk("tmo_done", 32'(obs()), 32'(pk(0, 255, 0, 255, 0, 0, 1, 0, 1)));
    tick(); chk("tmo_idle", 32'({busy, done, timeout_err}), 32'b001);

    // Pass 4: reset mid-pass aborts with no done pulse
    start = 1'b1; tick(); start = 1'b0;
    chk("terr_clr", 32'(timeout_err), 32'd0);
    run_to_op(128);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_abort", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst", 32'({op_ren, vg_ren, busy, done}), 32'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
